// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   state_e   : buffer occupancy state (EMPTY/ONE/TWO words held)
//   DSIZE_DEF : default data word width
package fifo_pkg;

  localparam int unsigned DSIZE_DEF = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_rd_stream.sv
// Converts the read port of an async FIFO into a valid/ready stream using a
// two-entry (head + skid) buffer, so rinc never depends on m_ready.
// Ports:
//   rclk, rrst_n     : read-domain clock, synchronous active-low reset
//   rempty, rdata    : FIFO empty flag and current read word
//   rinc             : read-increment request to the read-pointer stage
//   flush            : synchronous discard of buffered words
//   m_valid, m_data  : stream output (head entry)
//   m_ready          : consumer accept
//   buf_level        : number of buffered words (0..2)
//   xfer_cnt         : completed handshake count (wraps)
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       buf_level,
  output logic [CNTW-1:0]  xfer_cnt
);

  state_e           state_q;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] skid_q;
  logic             push;
  logic             pop;

  // Read request depends only on registered state and FIFO/flush/reset inputs;
  // gating with rrst_n keeps the pointer stage still while reset is held.
  assign rinc = rrst_n & ~rempty & ~flush & (state_q != ST_TWO);
  assign push = rinc;
  assign pop  = m_valid & m_ready & ~flush;

  assign m_valid   = (state_q != ST_EMPTY);
  assign m_data    = head_q;
  assign buf_level = 2'(state_q);

  // Occupancy FSM with head/skid storage and handshake counter.
  // head_q is cleared whenever the buffer empties so m_data reads 0 in EMPTY.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q  <= ST_EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      xfer_cnt <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      if (pop) begin
        xfer_cnt <= xfer_cnt + CNTW'(1);
      end
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_q <= ST_ONE;
            head_q  <= rdata;
          end
        end
        ST_ONE: begin
          case ({push, pop})
            2'b10: begin
              state_q <= ST_TWO;
              skid_q  <= rdata;
            end
            2'b01: begin
              state_q <= ST_EMPTY;
              head_q  <= '0;
            end
            2'b11: begin
              head_q <= rdata;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          // rinc is blocked in TWO, so only a pop can occur here.
          if (pop) begin
            state_q <= ST_ONE;
            head_q  <= skid_q;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          head_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed self-checking bench for fifo_rd_stream. A small array-backed source
// stands in for the FIFO memory/read pointer; a second instance with CNTW=4
// shares all inputs to observe counter wrap.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       flush;
  logic       m_ready;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc, rinc4;
  logic       m_valid, m_valid4;
  logic [7:0] m_data, m_data4;
  logic [1:0] buf_level, buf_level4;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;

  logic [7:0] src [0:63];
  logic [5:0] wr_idx = '0;
  logic [5:0] rd_idx = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out;

  always #5 rclk = ~rclk;

  assign rempty = (rd_idx == wr_idx);
  assign rdata  = src[rd_idx];

  always @(posedge rclk) if (rinc) rd_idx <= rd_idx + 6'd1;

  fifo_rd_stream #(.DSIZE(8), .CNTW(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .buf_level(buf_level), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.DSIZE(8), .CNTW(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
    .flush(flush), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
    .buf_level(buf_level4), .xfer_cnt(xfer_cnt4)
  );

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  task automatic load(input logic [7:0] d);
    src[wr_idx] = d;
    wr_idx = wr_idx + 6'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) src[i] = 8'h00;
    rrst_n  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    tick();
    load(8'hA5);
    tick();
    // Reset state, with a word available and consumer ready-less.
    chk("rst_m_valid",   32'(m_valid),   32'd0);
    chk("rst_m_data",    32'(m_data),    32'h0);
    chk("rst_buf_level", 32'(buf_level), 32'd0);
    chk("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
    chk("rst_rinc",      32'(rinc),      32'd0);

    // First word: rinc immediately after release, visible one cycle later.
    rrst_n = 1'b1;
    #1;
    chk("first_rinc", 32'(rinc), 32'd1);
    tick();
    chk("first_m_valid",   32'(m_valid),   32'd1);
    chk("first_m_data",    32'(m_data),    32'hA5);
    chk("first_buf_level", 32'(buf_level), 32'd1);
    chk("first_rinc_off",  32'(rinc),      32'd0);

    m_ready = 1'b1;
    tick();
    chk("drain_m_valid",  32'(m_valid),  32'd0);
    chk("drain_m_data",   32'(m_data),   32'h0);
    chk("drain_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // Stalled consumer fills both entries, then drains in order.
    m_ready = 1'b0;
    load(8'h01); load(8'h02); load(8'h03);
    tick();
    tick();
    chk("stall_buf_level", 32'(buf_level), 32'd2);
    chk("stall_rinc",      32'(rinc),      32'd0);
    chk("stall_m_data",    32'(m_data),    32'h01);
    tick();
    chk("hold_m_data",    32'(m_data),    32'h01);
    chk("hold_m_valid",   32'(m_valid),   32'd1);
    chk("hold_buf_level", 32'(buf_level), 32'd2);
    m_ready = 1'b1;
    tick();
    chk("order_02",      32'(m_data),    32'h02);
    chk("order_02_lvl",  32'(buf_level), 32'd1);
    tick();
    chk("order_03",      32'(m_data),    32'h03);
    tick();
    chk("order_empty",   32'(m_valid),   32'd0);
    chk("order_xfer",    32'(xfer_cnt),  32'd4);

    // Continuous stream of 16 words: 16 outputs in 17 cycles.
    for (int i = 0; i < 16; i++) load(8'h10 + 8'(i));
    n_out = 0;
    for (int c = 0; c < 17; c++) begin
      if (m_valid) begin
        chk("stream_data", 32'(m_data), 32'h10 + 32'(n_out));
        n_out++;
      end
      tick();
    end
    chk("stream_count", 32'(n_out),     32'd16);
    chk("stream_xfer",  32'(xfer_cnt),  32'd20);
    chk("stream_xfer4", 32'(xfer_cnt4), 32'd4);

    // Flush with two words buffered and consumer ready.
    m_ready = 1'b0;
    load(8'h31); load(8'h32);
    tick();
    tick();
    load(8'h33);
    chk("pre_flush_lvl", 32'(buf_level), 32'd2);
    flush   = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("flush_rinc", 32'(rinc), 32'd0);
    tick();
    flush   = 1'b0;
    m_ready = 1'b0;
    chk("flush_m_valid", 32'(m_valid),   32'd0);
    chk("flush_lvl",     32'(buf_level), 32'd0);
    chk("flush_xfer",    32'(xfer_cnt),  32'd20);
    chk("flush_m_data",  32'(m_data),    32'h0);
    tick();
    chk("post_flush_data", 32'(m_data), 32'h33);

    // Reset with two words buffered, then a 17-word stream.
    load(8'h34);
    tick();
    chk("pre_rst_lvl",  32'(buf_level), 32'd2);
    chk("pre_rst_data", 32'(m_data),    32'h33);
    rrst_n = 1'b0;
    load(8'h40);
    tick();
    chk("mid_rst_m_valid", 32'(m_valid),   32'd0);
    chk("mid_rst_m_data",  32'(m_data),    32'h0);
    chk("mid_rst_lvl",     32'(buf_level), 32'd0);
    chk("mid_rst_xfer",    32'(xfer_cnt),  32'd0);
    chk("mid_rst_rinc",    32'(rinc),      32'd0);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    for (int i = 1; i < 17; i++) load(8'h40 + 8'(i));
    n_out = 0;
    for (int c = 0; c < 18; c++) begin
      if (m_valid) begin
        chk("resume_data", 32'(m_data), 32'h40 + 32'(n_out));
        n_out++;
      end
      tick();
    end
    chk("resume_count", 32'(n_out),     32'd17);
    chk("resume_xfer",  32'(xfer_cnt),  32'd17);
    chk("wrap_xfer4",   32'(xfer_cnt4), 32'd1);
    chk("resume_empty", 32'(m_valid),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
